// File: rtl/mem_arbiter.sv
// Shares one block memory between an i-side reader and a d-side reader/writer, round-robin on ties.
// Command issues the edge a request is seen in IDLE; completion pulses one cycle after mem_ready/mem_done; losers hold req.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ready,
  output logic [BLOCK_W-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_ready,
  output logic               d_done,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_din,
  input  logic               mem_ready,
  input  logic               mem_done,
  input  logic [BLOCK_W-1:0] mem_dout,
  output logic               busy,
  output logic               err_timeout
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, GAP = 2'd3} state_t;

  state_t           state, state_d;
  logic             last_d;  // owner of the current/last grant; 0 lets the d-side win the next tie
  logic             grant;
  logic             sel_d;
  logic             in_xfer;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    grant   = 1'b0;
    sel_d   = d_req && (!i_req || !last_d);
    in_xfer = (state == RD) || (state == WR);
    cnt_d   = cnt_q;
    cnt_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = (sel_d && d_we) ? WR : RD;
        end
      end
      RD:      if (mem_ready) state_d = GAP;
      WR:      if (mem_done)  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant)                            cnt_d = '0;
    else if (in_xfer && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    cnt_hit = (grant || in_xfer) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_d      <= 1'b0;
      cnt_q       <= '0;
      err_timeout <= 1'b0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      busy        <= 1'b0;
      i_ready     <= 1'b0;
      i_rdata     <= '0;
      d_ready     <= 1'b0;
      d_done      <= 1'b0;
      d_rdata     <= '0;
    end else begin
      mem_ren <= (state_d == RD);
      mem_wen <= (state_d == WR);
      busy    <= (state_d == RD) || (state_d == WR);
      cnt_q   <= cnt_d;
      if (cnt_hit) err_timeout <= 1'b1;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      d_done  <= 1'b0;
      if (grant) begin
        last_d   <= sel_d;
        mem_addr <= sel_d ? d_addr : i_addr;
        if (sel_d) mem_din <= d_wdata;
      end
      // Completion goes to whoever owns the grant, even if its req has since dropped.
      if (state == RD && mem_ready) begin
        if (last_d) begin
          d_rdata <= mem_dout;
          d_ready <= 1'b1;
        end else begin
          i_rdata <= mem_dout;
          i_ready <= 1'b1;
        end
      end
      if (state == WR && mem_done) d_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and directed corner cases.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int BW = 128;
  localparam int TO = 8;
  localparam int HALF = 1 << (AW - 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready;
  logic [BW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [BW-1:0] d_wdata = '0;
  logic          d_ready, d_done;
  logic [BW-1:0] d_rdata;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_din;
  logic          mem_ready = 1'b0;
  logic          mem_done = 1'b0;
  logic [BW-1:0] mem_dout = '0;
  logic          busy, err_timeout;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_done(d_done), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    bit            is_wr;
    logic [BW-1:0] data;
  } d_exp_t;

  int            tests = 0;
  int            fails = 0;
  logic [BW-1:0] iq[$];
  d_exp_t        dq[$];
  logic [BW-1:0] ref_mem[0:(1<<AW)-1];
  logic [BW-1:0] store[0:(1<<AW)-1];
  int            force_delay = -1;
  bit            m_active = 1'b0;
  int            m_wait = 0;
  bit            mon_prev = 1'b0;
  logic [AW-1:0] mon_addr = '0;
  logic [BW-1:0] mon_din = '0;

  function automatic logic [BW-1:0] init_val(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(a)};
  endfunction

  function automatic d_exp_t mk(input bit wr, input logic [BW-1:0] data);
    d_exp_t e;
    e.is_wr = wr;
    e.data  = data;
    return e;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred=1, expected 0", name);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int t = 0; t < budget && (iq.size() != 0 || dq.size() != 0); t++) cyc();
    chk(name, BW'(iq.size() + dq.size()), BW'(0));
  endtask

  // Memory: answers after a random (or forced) delay, injects stray and wrong-type flags otherwise.
  initial begin : memory_model
    forever begin
      cyc();
      mem_ready = 1'b0;
      mem_done  = 1'b0;
      if (mem_ren || mem_wen) begin
        if (!m_active) begin
          m_active = 1'b1;
          if (force_delay >= 0)       m_wait = force_delay;
          else if (force_delay == -2) m_wait = 32'h3FFF_FFFF;
          else                        m_wait = $urandom_range(0, 4);
        end
        if (m_wait == 0) begin
          if (mem_ren) begin
            mem_ready = 1'b1;
            mem_dout  = store[mem_addr];
          end else begin
            mem_done        = 1'b1;
            store[mem_addr] = mem_din;
          end
        end else begin
          m_wait--;
          if ($urandom_range(0, 3) == 0) begin
            if (mem_ren) mem_done = 1'b1;
            else begin
              mem_ready = 1'b1;
              mem_dout  = {$urandom, $urandom, $urandom, $urandom};
            end
          end
        end
      end else begin
        m_active = 1'b0;
        if ($urandom_range(0, 5) == 0) begin
          mem_ready = 1'b1;
          mem_done  = 1'b1;
          mem_dout  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  initial begin : monitor
    logic [BW-1:0] ie;
    d_exp_t        de;
    forever begin
      cyc();
      chk("ren_wen_exclusive", BW'(mem_ren & mem_wen), BW'(0));
      chk("busy_vs_cmd", BW'(busy), BW'(mem_ren | mem_wen));
      if (i_ready) begin
        if (iq.size() == 0) bad("i_ready_unexpected");
        else begin
          ie = iq.pop_front();
          chk("i_rdata", i_rdata, ie);
        end
      end
      if (d_ready || d_done) begin
        if (dq.size() == 0) bad("d_pulse_unexpected");
        else begin
          de = dq.pop_front();
          if (de.is_wr) chk("d_done_kind", BW'({d_done, d_ready}), BW'(2'b10));
          else begin
            chk("d_ready_kind", BW'({d_done, d_ready}), BW'(2'b01));
            chk("d_rdata", d_rdata, de.data);
          end
        end
      end
      if (i_ready || d_ready || d_done)
        chk("gap_on_pulse", BW'({mem_ren, mem_wen, busy}), BW'(0));
      if ((mem_ren || mem_wen) && mon_prev) begin
        chk("mem_addr_stable", BW'(mem_addr), BW'(mon_addr));
        if (mem_wen) chk("mem_din_stable", mem_din, mon_din);
      end
      mon_prev = mem_ren || mem_wen;
      mon_addr = mem_addr;
      mon_din  = mem_din;
    end
  end

  task automatic i_driver(input int n);
    bit            keep;
    logic [AW-1:0] a;
    keep = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!keep) repeat ($urandom_range(0, 3)) cyc();
      a = AW'($urandom_range(0, HALF - 1));
      i_addr = a;
      i_req  = 1'b1;
      iq.push_back(ref_mem[a]);
      cyc();
      for (int t = 0; t < 300 && !i_ready; t++) cyc();
      if (!i_ready) bad("i_wait_budget");
      keep = ($urandom_range(0, 1) == 1) && (k != n - 1);
      if (!keep) i_req = 1'b0;
    end
  endtask

  task automatic d_driver(input int n);
    bit            keep;
    logic [AW-1:0] a;
    logic [BW-1:0] w;
    keep = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!keep) repeat ($urandom_range(0, 3)) cyc();
      a = AW'(HALF + $urandom_range(0, HALF - 1));
      d_addr = a;
      d_we   = ($urandom_range(0, 1) == 1);
      if (d_we) begin
        w       = {$urandom, $urandom, $urandom, $urandom};
        d_wdata = w;
        ref_mem[a] = w;
        dq.push_back(mk(1'b1, w));
      end else dq.push_back(mk(1'b0, ref_mem[a]));
      d_req = 1'b1;
      cyc();
      for (int t = 0; t < 300 && !(d_ready || d_done); t++) cyc();
      if (!(d_ready || d_done)) bad("d_wait_budget");
      keep = ($urandom_range(0, 1) == 1) && (k != n - 1);
      if (!keep) d_req = 1'b0;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   n;
    int   ngr;
    int   low;
    bit   prev;
    bit   cmd;
    bit   flag;
    for (int a = 0; a < (1 << AW); a++) begin
      ref_mem[a] = init_val(a);
      store[a]   = init_val(a);
    end

    // Reset values
    cyc();
    cyc();
    chk("rst_i_ready", BW'(i_ready), BW'(0));
    chk("rst_i_rdata", i_rdata, BW'(0));
    chk("rst_d_ready", BW'(d_ready), BW'(0));
    chk("rst_d_done", BW'(d_done), BW'(0));
    chk("rst_d_rdata", d_rdata, BW'(0));
    chk("rst_mem_cmd", BW'({mem_ren, mem_wen}), BW'(0));
    chk("rst_mem_addr", BW'(mem_addr), BW'(0));
    chk("rst_mem_din", mem_din, BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_err", BW'(err_timeout), BW'(0));
    reset = 1'b1;

    // Single i-side read, memory answers on the 4th ren cycle
    ref_mem[5]  = BW'(8'hA5);
    store[5]    = BW'(8'hA5);
    force_delay = 3;
    i_addr = 10'h005;
    i_req  = 1'b1;
    iq.push_back(BW'(8'hA5));
    cyc();
    n = 0;
    while (mem_ren && n < 50) begin
      chk("t1_mem_addr", BW'(mem_addr), BW'(10'h005));
      n++;
      cyc();
    end
    i_req = 1'b0;
    chk("t1_ren_cycles", BW'(n), BW'(4));
    chk("t1_i_ready", BW'(i_ready), BW'(1));
    cyc();
    chk("t1_single_pulse", BW'(i_ready), BW'(0));
    chk("t1_idle_after_gap", BW'({busy, mem_ren}), BW'(0));
    chk("t1_rdata_held", i_rdata, BW'(8'hA5));

    // Single d-side write
    force_delay = 2;
    d_addr  = 10'h010;
    d_wdata = BW'(16'h1234);
    d_we    = 1'b1;
    d_req   = 1'b1;
    ref_mem[16] = BW'(16'h1234);
    dq.push_back(mk(1'b1, BW'(16'h1234)));
    cyc();
    n    = 0;
    flag = 1'b0;
    while (mem_wen && n < 50) begin
      if (n == 0) begin
        chk("t2_mem_addr", BW'(mem_addr), BW'(10'h010));
        chk("t2_mem_din", mem_din, BW'(16'h1234));
      end
      flag = flag | mem_ren;
      n++;
      cyc();
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    chk("t2_wen_cycles", BW'(n), BW'(3));
    chk("t2_d_done", BW'(d_done), BW'(1));
    chk("t2_ren_never", BW'(flag), BW'(0));
    cyc();
    chk("t2_single_done", BW'(d_done), BW'(0));

    // Both sides held after reset: grants alternate d, i, d, i
    do_reset();
    force_delay = -1;
    i_addr = 10'h003;
    d_addr = 10'h300;
    d_we   = 1'b0;
    iq.push_back(ref_mem[3]);
    iq.push_back(ref_mem[3]);
    dq.push_back(mk(1'b0, ref_mem[10'h300]));
    dq.push_back(mk(1'b0, ref_mem[10'h300]));
    i_req = 1'b1;
    d_req = 1'b1;
    ngr  = 0;
    low  = 0;
    prev = 1'b0;
    for (int t = 0; t < 200 && ngr < 4; t++) begin
      cyc();
      cmd = mem_ren | mem_wen;
      if (cmd && !prev) begin
        chk($sformatf("t3_grant%0d_side", ngr), BW'(mem_addr[AW-1]), BW'((ngr % 2 == 0) ? 1 : 0));
        if (ngr > 0) chk("t3_idle_between", BW'(low), BW'(2));
        ngr++;
        low = 0;
      end else if (!cmd) low++;
      prev = cmd;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("t3_grants", BW'(ngr), BW'(4));
    drain("t3_drain", 100);

    // Randomized concurrent traffic
    repeat (2) cyc();
    fork
      i_driver(60);
      d_driver(60);
    join
    drain("rand_drain", 100);
    chk("rand_no_timeout", BW'(err_timeout), BW'(0));

    // d-side read whose req drops after one cycle still completes
    repeat (2) cyc();
    force_delay = 3;
    d_addr = 10'h2AA;
    d_we   = 1'b0;
    dq.push_back(mk(1'b0, ref_mem[10'h2AA]));
    d_req = 1'b1;
    cyc();
    chk("t5_busy", BW'(busy), BW'(1));
    d_req = 1'b0;
    flag  = 1'b0;
    for (int t = 0; t < 50 && !flag; t++) begin
      cyc();
      flag = d_ready;
    end
    chk("t5_d_ready", BW'(flag), BW'(1));

    // Reset during RD: command drops, no completion, fresh request works
    repeat (2) cyc();
    force_delay = 20;
    i_addr = 10'h007;
    i_req  = 1'b1;
    repeat (3) cyc();
    chk("t6_in_rd", BW'(mem_ren), BW'(1));
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    i_req = 1'b0;
    chk("t6_ren_drop", BW'(mem_ren), BW'(0));
    chk("t6_busy_drop", BW'(busy), BW'(0));
    chk("t6_rdata_cleared", d_rdata | i_rdata, BW'(0));
    flag = 1'b0;
    repeat (5) begin
      cyc();
      flag = flag | i_ready | d_ready | d_done | mem_ren | mem_wen;
    end
    chk("t6_quiet", BW'(flag), BW'(0));
    force_delay = -1;
    iq.push_back(ref_mem[7]);
    i_req = 1'b1;
    flag  = 1'b0;
    for (int t = 0; t < 50 && !flag; t++) begin
      cyc();
      flag = i_ready;
    end
    i_req = 1'b0;
    chk("t6_fresh_done", BW'(flag), BW'(1));

    // Memory never answers: sticky timeout after TO busy cycles
    repeat (2) cyc();
    force_delay = -2;
    i_addr = 10'h008;
    i_req  = 1'b1;
    cyc();
    chk("t7_busy", BW'(busy), BW'(1));
    n = 1;
    while (n < TO) begin
      cyc();
      n++;
    end
    chk("t7_err_before", BW'(err_timeout), BW'(0));
    cyc();
    chk("t7_err_set", BW'(err_timeout), BW'(1));
    repeat (10) cyc();
    chk("t7_err_sticky", BW'(err_timeout), BW'(1));
    chk("t7_still_waiting", BW'(mem_ren), BW'(1));
    reset = 1'b0;
    i_req = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t7_err_clear", BW'(err_timeout), BW'(0));
    chk("t7_ren_clear", BW'(mem_ren), BW'(0));
    force_delay = -1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
